// File: rtl/ld_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P in Lopez-Dahab coordinates over GF(2^N).
// Drives external combinational add/double units and resolves the O, Q==P and Q==-P cases itself.
module ld_scalar_mult_ctrl #(
   parameter int          N    = 3,
   parameter int          K_W  = 4,
   parameter logic [N-1:0] POLY = 3'b011
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [K_W-1:0] k,
   input  logic [N-1:0]   px,
   input  logic [N-1:0]   py,
   input  logic [N-1:0]   pz,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   qx,
   output logic [N-1:0]   qy,
   output logic [N-1:0]   qz,
   output logic [3*N-1:0] add_p0,
   output logic [3*N-1:0] add_p1,
   input  logic [3*N-1:0] add_r,
   output logic [3*N-1:0] dbl_p,
   input  logic [3*N-1:0] dbl_r
);

   localparam int             IW      = (K_W > 1) ? $clog2(K_W) : 1;
   localparam logic [IW-1:0]  IDX_TOP = IW'(K_W - 1);

   typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;

   state_t         state, state_next;
   logic [IW-1:0]  idx, idx_next;
   logic [K_W-1:0] k_reg;
   logic [3*N-1:0] base;
   logic [3*N-1:0] acc, acc_next;
   logic [3*N-1:0] q_out;
   logic           load_out;

   logic [N-1:0]   acc_x, acc_y, acc_z;
   logic [N-1:0]   base_x, base_y, base_z;
   logic [N-1:0]   z_sq;
   logic           q_inf, x_match, q_is_p, q_is_neg;
   logic           dbl_use_p;

   // Shift-and-add carry-less multiply, reducing by x^N + POLY on every shift.
   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] acc_m;
      logic [N-1:0] sh;
      acc_m = '0;
      sh    = a;
      for (int i = 0; i < N; i++) begin
         if (b[i]) acc_m = acc_m ^ sh;
         sh = sh[N-1] ? ((sh << 1) ^ POLY) : (sh << 1);
      end
      return acc_m;
   endfunction

   assign {acc_x, acc_y, acc_z}    = acc;
   assign {base_x, base_y, base_z} = base;

   // Projective comparisons against the affine base point (Z_P = 1).
   assign z_sq     = gf_mul(acc_z, acc_z);
   assign q_inf    = (acc_z == '0);
   assign x_match  = (acc_x == gf_mul(base_x, acc_z));
   assign q_is_p   = x_match && (acc_y == gf_mul(base_y, z_sq));
   assign q_is_neg = x_match && (acc_y == gf_mul(base_x ^ base_y, z_sq));

   assign dbl_use_p = (state == ADD) && !q_inf && q_is_p;

   assign add_p0 = acc;
   assign add_p1 = base;
   assign dbl_p  = dbl_use_p ? base : acc;

   assign busy = (state == DBL) || (state == ADD);
   assign done = (state == DONE);
   assign {qx, qy, qz} = q_out;

   always_comb begin
      state_next = state;
      idx_next   = idx;
      acc_next   = acc;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DBL;
               idx_next   = IDX_TOP;
               acc_next   = '0;
            end
         end
         DBL: begin
            if (!q_inf) acc_next = dbl_r;
            if (k_reg[idx]) begin
               state_next = ADD;
            end else if (idx == '0) begin
               state_next = DONE;
            end else begin
               idx_next = idx - IW'(1);
            end
         end
         ADD: begin
            if (q_inf)         acc_next = base;
            else if (q_is_p)   acc_next = dbl_r;
            else if (q_is_neg) acc_next = '0;
            else               acc_next = add_r;
            if (idx == '0) begin
               state_next = DONE;
            end else begin
               state_next = DBL;
               idx_next   = idx - IW'(1);
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result is captured as DONE is entered so it is already valid during the done pulse.
   assign load_out = (state_next == DONE) && (state != DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         k_reg <= '0;
         base  <= '0;
         acc   <= '0;
         q_out <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         acc   <= acc_next;
         if ((state == IDLE) && start) begin
            k_reg <= k;
            base  <= {px, py, pz};
         end
         if (load_out) q_out <= acc_next;
      end
   end

endmodule

// File: tb/tb_ld_scalar_mult_ctrl.sv
// Bench for ld_scalar_mult_ctrl: behavioural doubler/adder units, an operation-level model of k*P,
// directed special-case runs and randomized runs with ignored start pulses.
module tb_ld_scalar_mult_ctrl;

   localparam int          N    = 3;
   localparam int          K_W  = 4;
   localparam logic [2:0]  POLY = 3'b011;
   localparam logic [8:0]  P0   = {3'b110, 3'b001, 3'b001};

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [K_W-1:0] k = '0;
   logic [N-1:0]   px = '0, py = '0, pz = '0;
   logic           busy, done;
   logic [N-1:0]   qx, qy, qz;
   logic [3*N-1:0] add_p0, add_p1, add_r, dbl_p, dbl_r;

   int checks = 0;
   int errors = 0;
   int dmode  = 0;
   int amode  = 0;

   ld_scalar_mult_ctrl #(.N(N), .K_W(K_W), .POLY(POLY)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k(k),
      .px(px), .py(py), .pz(pz),
      .busy(busy), .done(done), .qx(qx), .qy(qy), .qz(qz),
      .add_p0(add_p0), .add_p1(add_p1), .add_r(add_r),
      .dbl_p(dbl_p), .dbl_r(dbl_r)
   );

   always #5 clk = ~clk;

   // Full polynomial product, then reduction by x^3 + x + 1.
   function automatic logic [2:0] gfm(input logic [2:0] a, input logic [2:0] b);
      logic [4:0] p;
      p = '0;
      for (int i = 0; i < 3; i++)
         if (b[i]) p = p ^ (5'(a) << i);
      for (int j = 4; j >= 3; j--)
         if (p[j]) p = p ^ (5'({1'b1, POLY}) << (j - 3));
      return p[2:0];
   endfunction

   // Lopez-Dahab doubling for y^2 + xy = x^3 + x^2 + 1.
   function automatic logic [8:0] ld_double(input logic [8:0] p);
      logic [2:0] x, y, z, z2, x2, z4, z3, x3, y3;
      {x, y, z} = p;
      z2 = gfm(z, z);
      x2 = gfm(x, x);
      z4 = gfm(z2, z2);
      z3 = gfm(x2, z2);
      x3 = gfm(x2, x2) ^ z4;
      y3 = gfm(z4, z3) ^ gfm(x3, z3 ^ gfm(y, y) ^ z4);
      return {x3, y3, z3};
   endfunction

   function automatic logic [8:0] unit_dbl(input logic [8:0] p, input int dm, input logic [8:0] b);
      if (dm == 1) return b;
      if (dm == 2) return {b[8:6], b[8:6] ^ b[5:3], b[2:0]};
      return ld_double(p);
   endfunction

   function automatic logic [8:0] unit_add(input logic [8:0] q, input logic [8:0] p, input int am);
      if (am == 1) return 9'b101_101_101;
      return {q[8:6] ^ p[8:6] ^ 3'b001,
              gfm(q[5:3], p[5:3]) ^ q[2:0],
              gfm(q[2:0], p[8:6]) ^ p[5:3]};
   endfunction

   always_comb begin
      dbl_r = unit_dbl(dbl_p, dmode, {px, py, pz});
      add_r = unit_add(add_p0, add_p1, amode);
   end

   // Operation-level double-and-add with the special-case rules.
   function automatic logic [8:0] model_q(input logic [3:0] kk, input logic [8:0] p,
                                          input int dm, input int am);
      logic [2:0] x, y, z, bx, by, bz;
      logic [8:0] q;
      q = '0;
      {bx, by, bz} = p;
      for (int i = K_W - 1; i >= 0; i--) begin
         if (q[2:0] != 3'b000) q = unit_dbl(q, dm, p);
         if (kk[i]) begin
            {x, y, z} = q;
            if (z == 3'b000)
               q = p;
            else if (x == gfm(bx, z) && y == gfm(by, gfm(z, z)))
               q = unit_dbl(p, dm, p);
            else if (x == gfm(bx, z) && y == gfm(bx ^ by, gfm(z, z)))
               q = '0;
            else
               q = unit_add(q, p, am);
         end
      end
      return q;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One accepted start, then cycle-by-cycle comparison until one cycle past the done pulse.
   task automatic run_op(input logic [3:0] kk, input logic [8:0] p, input bit noise,
                         input int dblp_cyc, output logic [8:0] qres);
      logic [8:0] exp_q, prev_q;
      int lat;
      exp_q  = model_q(kk, p, dmode, amode);
      lat    = K_W + $countones(kk) + 1;
      prev_q = {qx, qy, qz};
      qres   = '0;
      @(negedge clk);
      k = kk;
      {px, py, pz} = p;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= lat; cyc++) begin
         @(negedge clk);
         chk("busy", 32'(busy), 32'(cyc < lat));
         chk("done", 32'(done), 32'(cyc == lat));
         if (cyc < lat) begin
            chk("q_hold", 32'({qx, qy, qz}), 32'(prev_q));
            chk("add_p1", 32'(add_p1), 32'(p));
            if (cyc == dblp_cyc) chk("dbl_p_is_P", 32'(dbl_p), 32'(p));
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) k = 4'($urandom);
         end else begin
            start = 1'b0;
            chk("q_result", 32'({qx, qy, qz}), 32'(exp_q));
            qres = {qx, qy, qz};
         end
      end
      @(negedge clk);
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [8:0] r;
      logic [8:0] rp;
      logic [3:0] rk;

      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'({qx, qy, qz}), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Model pinned to hand-derived values.
      chk("model_k2", 32'(model_q(4'b0010, P0, 0, 0)), 32'({3'b101, 3'b011, 3'b010}));
      chk("model_negp", 32'(model_q(4'b0011, P0, 2, 0)), 32'd0);

      run_op(4'b0000, P0, 1'b0, -1, r);
      chk("k0_q", 32'(r), 32'd0);

      run_op(4'b0001, P0, 1'b0, -1, r);
      chk("k1_q", 32'(r), 32'(P0));

      // Abort a k=1111 run in cycle 3.
      @(negedge clk);
      k = 4'b1111;
      {px, py, pz} = P0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 chk("abort_busy_before", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q", 32'({qx, qy, qz}), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_op(4'b0010, P0, 1'b0, -1, r);
      chk("k2_affine_x", 32'(r[8:6]), 32'(gfm(3'b111, r[2:0])));
      chk("k2_affine_y", 32'(r[5:3]), 32'(gfm(3'b010, gfm(r[2:0], r[2:0]))));
      chk("k2_z_nonzero", 32'(r[2:0] != 3'b000), 32'd1);

      dmode = 1;
      amode = 1;
      run_op(4'b0011, P0, 1'b0, 6, r);
      chk("qeqp_q", 32'(r), 32'(P0));

      dmode = 2;
      amode = 0;
      run_op(4'b0011, P0, 1'b1, -1, r);
      chk("qnegp_q", 32'(r), 32'd0);

      for (int n = 0; n < 30; n++) begin
         dmode = (n % 5 == 4) ? int'($urandom_range(1, 2)) : 0;
         amode = 0;
         rk = 4'($urandom);
         rp = {3'($urandom), 3'($urandom), 3'b001};
         run_op(rk, rp, 1'($urandom_range(0, 1)), -1, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ld_scalar_mult_ctrl.md
Name: ld_scalar_mult_ctrl

Overview:
- Sequencer computing Q = k·P over GF(2^N) in Lopez-Dahab projective coordinates, using left-to-right double-and-add.
- Drives an external combinational pointAddition unit and an external combinational point-doubling unit through packed operand/result buses, then registers each result.
- Handles the special cases the formula units do not cover: point at infinity O, Q == P and Q == -P.
- Sits above pointAddition as the top-level scalar-multiplication controller.

Parameters:
- N, 3, field width in bits; coordinates are N bits.
- K_W, 4, scalar width in bits.
- POLY, 3'b011, low N bits of the irreducible polynomial (default x^3+x+1), used by the internal GF multiplier.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request pulse; sampled only in IDLE.
- k  in  K_W  scalar; latched on accepted start.
- px, py, pz  in  N each  base point P; latched on accepted start; pz must be 1 (affine input).
- busy  out  1  high in DBL and ADD.
- done  out  1  one-cycle pulse in DONE.
- qx, qy, qz  out  N each  result register; valid from the done cycle until the next accepted start.
- add_p0, add_p1  out  3N each  adder operands {X,Y,Z}; add_p0 = Q, add_p1 = P.
- add_r  in  3N  adder result {X2,Y2,Z2}.
- dbl_p  out  3N  doubler operand = Q.
- dbl_r  in  3N  doubler result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; qx/qy/qz=0; idx=0; latched k/P=0.
- Representation: O is {0,0,0}; any Q with Z=0 is treated as O.
- Operand buses are continuously driven from the Q/P registers and are don't-care outside DBL/ADD.
- IDLE:
  - start=1 latches k and P, sets Q=O and idx=K_W-1, goes to DBL.
  - start is ignored in every other state; no queuing.
- DBL (one cycle):
  - If Q is O, Q stays O and dbl_r is ignored; otherwise Q <= dbl_r.
  - Next state: ADD if k[idx]=1; else DONE if idx=0; else idx <= idx-1, stay in DBL.
- ADD (one cycle), evaluated in priority order:
  - (a) Q is O: Q <= P.
  - (b) X_Q == X_P·Z_Q and Y_Q == Y_P·Z_Q^2 (Q==P): Q <= dbl_r, with dbl_p driven as P in this case.
  - (c) X_Q == X_P·Z_Q and Y_Q == (X_P+Y_P)·Z_Q^2 (Q==-P): Q <= O.
  - (d) otherwise: Q <= add_r.
  - Next state: DONE if idx=0; else idx <= idx-1, go to DBL.
- GF arithmetic: products are computed modulo x^N+POLY with carry-less multiply-reduce; additions are XOR. All comparisons use full N-bit values.
- DONE: done=1 and qx/qy/qz <= Q. The next state is IDLE.
- Latency:
  - The start sample edge is cycle 0.
  - done is high in cycle K_W + popcount(k) + 1.
  - The schedule is fixed per k and is never shortened for leading zeros.
- Reset mid-operation aborts immediately to the reset values. No done is produced.
- q outputs keep their previous value while busy.

Test Plan:
- Reset mid-run: start with k=4'b1111, then pull rst_n low in cycle 3. Required: busy=0, done=0 and q=000 asynchronously (same cycle, before the next edge); a start after release runs normally.
- k=0, P=(110,001,001): DBL ×4, no ADD. Required: done in cycle 5, q=(000,000,000), busy high in cycles 1-4.
- k=1, P=(110,001,001) with the real pointAddition and the model doubler: 4 DBL of O, then ADD case (a). Required: done in cycle 6, q=(110,001,001).
- k=2, P=(110,001,001): ADD case (a), then DBL of P. Required: done in cycle 6, q affine-equal to 2P=(111,010); the bench checks x=X/Z and y=Y/Z².
- Stub units, Q forced equal to P at an ADD (k=4'b0011; stub dbl_r returns P in the preceding DBL). Required: in the ADD cycle, dbl_p == {px,py,pz}; the Q update takes dbl_r; add_r (driven with 3'b101 patterns) is ignored.
- Stub dbl_r returns -P=(110,111,001) before an ADD with P=(110,001,001). Required: case (c) is taken and the final q=(000,000,000). start pulses while busy are ignored, with no change in the done timing.
